// File: rtl/q_action_select.sv
// Buffers one Q vector, scans it for the max (ties keep the lowest index), then emits an epsilon-greedy action;
// strobe N+2 edges after the last beat; no backpressure, beats arriving while busy are dropped and flagged on o_error.
module q_action_select #(
   parameter int          DATA_WIDTH            = 32,
   parameter int          ADDR_WIDTH            = 3,
   parameter int          NUMBER_OF_OUTPUT_NODE = 3,
   parameter int          ACTION_WIDTH          = 2,
   parameter logic [15:0] EPSILON               = 16'h0CCD,
   parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_data_valid,
   input  logic [ADDR_WIDTH-1:0]   i_data_addr,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_explore_enable,
   output logic [ACTION_WIDTH-1:0] o_action,
   output logic [DATA_WIDTH-1:0]   o_q_max,
   output logic                    o_greedy,
   output logic                    o_action_valid,
   output logic                    o_busy,
   output logic                    o_error
);

   localparam int N = NUMBER_OF_OUTPUT_NODE;
   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_COMPARE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [N-1:0] MASK_FULL = {N{1'b1}};
   localparam logic [ACTION_WIDTH-1:0] LAST_IDX = ACTION_WIDTH'(N - 1);

   logic [DATA_WIDTH-1:0]   q_buf [N];
   logic [1:0]              state_q, state_d;
   logic [N-1:0]            mask_q, mask_d, hit;
   logic [ACTION_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   best_q, best_d;
   logic [ACTION_WIDTH-1:0] best_idx_q, best_idx_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [ACTION_WIDTH-1:0] rand_q, rand_d;
   logic                    explore_q, explore_d;
   logic [ACTION_WIDTH-1:0] rand_pick_q, rand_pick_d;
   logic [ACTION_WIDTH-1:0] action_q, action_d;
   logic [DATA_WIDTH-1:0]   q_max_q, q_max_d;
   logic                    greedy_q, greedy_d;
   logic                    valid_q, valid_d;
   logic                    error_q, error_d;
   logic                    addr_ok, wr_en;
   logic [DATA_WIDTH-1:0]   cur;

   // Strict IEEE-754 greater-than: NaN never wins, but anything non-NaN beats a NaN incumbent.
   function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      logic a_nan, b_nan, res;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan)
         res = 1'b0;
      else if (b_nan)
         res = 1'b1;
      else if ((a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0))
         res = 1'b0;
      else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
         res = ~a[DATA_WIDTH-1];
      else if (!a[DATA_WIDTH-1])
         res = a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
      else
         res = a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
      return res;
   endfunction

   assign addr_ok = (32'(i_data_addr) < 32'(N));
   assign wr_en   = (state_q == S_COLLECT) && i_data_valid && addr_ok;

   always_comb begin
      hit = '0;
      cur = q_buf[0];
      for (int i = 0; i < N; i++) begin
         hit[i] = (i_data_addr == ADDR_WIDTH'(i));
         if (idx_q == ACTION_WIDTH'(i))
            cur = q_buf[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (wr_en && hit[i])
            q_buf[i] <= i_data;
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      idx_d       = idx_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      explore_d   = explore_q;
      rand_pick_d = rand_pick_q;
      action_d    = action_q;
      q_max_d     = q_max_q;
      greedy_d    = greedy_q;
      valid_d     = 1'b0;
      error_d     = error_q;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      rand_d      = (rand_q == LAST_IDX) ? '0 : rand_q + ACTION_WIDTH'(1);
      case (state_q)
         S_COLLECT: begin
            idx_d = '0;
            if (i_data_valid) begin
               if (addr_ok)
                  mask_d = mask_q | hit;
               else
                  error_d = 1'b1;
            end
            if (mask_d == MASK_FULL)
               state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (i_data_valid)
               error_d = 1'b1;
            if (idx_q == '0) begin
               best_d     = cur;
               best_idx_d = '0;
            end else if (fp_gt(cur, best_q)) begin
               best_d     = cur;
               best_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d     = S_DONE;
               explore_d   = i_explore_enable && (lfsr_q < EPSILON);
               rand_pick_d = rand_q;
            end else begin
               idx_d = idx_q + ACTION_WIDTH'(1);
            end
         end
         S_DONE: begin
            if (i_data_valid)
               error_d = 1'b1;
            valid_d  = 1'b1;
            q_max_d  = best_q;
            action_d = explore_q ? rand_pick_q : best_idx_q;
            greedy_d = ~explore_q;
            mask_d   = '0;
            state_d  = S_COLLECT;
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_COLLECT;
         mask_q      <= '0;
         idx_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         lfsr_q      <= SEED;
         rand_q      <= '0;
         explore_q   <= 1'b0;
         rand_pick_q <= '0;
         action_q    <= '0;
         q_max_q     <= '0;
         greedy_q    <= 1'b0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         idx_q       <= idx_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         lfsr_q      <= lfsr_d;
         rand_q      <= rand_d;
         explore_q   <= explore_d;
         rand_pick_q <= rand_pick_d;
         action_q    <= action_d;
         q_max_q     <= q_max_d;
         greedy_q    <= greedy_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign o_action       = action_q;
   assign o_q_max        = q_max_q;
   assign o_greedy       = greedy_q;
   assign o_action_valid = valid_q;
   assign o_busy         = (state_q == S_COMPARE) || (state_q == S_DONE);
   assign o_error        = error_q;

endmodule
